// File: rtl/row_scan_sequencer.sv
// row_scan_sequencer: walks every (group, block-row) of the grid: fetch, blank, then drive each row for a fixed dwell.
// Define ROW_SCAN_FRAME_COUNT_EN to add a wrapping 16-bit frame counter with synchronous clear.
module row_scan_sequencer #(
    parameter int NUM_GROUPS = 19,
    parameter int NUM_BLOCKS = 9,
    parameter int DWELL      = 64,
    parameter int BLANK      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_enable,
    output logic       io_dataReq,
    input  logic       io_dataAck,
    output logic [5:0] io_nextRAddr,
    output logic [3:0] io_nextBAddr,
    output logic [5:0] io_rAddr,
    output logic [3:0] io_bAddr,
    output logic       io_latch,
    output logic       io_frameDone,
`ifdef ROW_SCAN_FRAME_COUNT_EN
    input  logic        io_frameCountClr,
    output logic [15:0] io_frameCount,
`endif
    output logic       io_busy
);
    localparam int CMAX = DWELL > BLANK ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;
    localparam logic [1:0] S_DRIVE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    r_q, r_d;
    logic [3:0]    b_q, b_d;
    logic          cnt_zero, last_b, last_r;
    logic          drive_d, latch_d, frame_done_d;

    assign cnt_zero = cnt_q == '0;
    assign last_b   = b_q == 4'(NUM_BLOCKS - 1);
    assign last_r   = r_q == 6'(NUM_GROUPS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE:  if (io_enable) state_d = S_FETCH;
            S_FETCH: if (io_dataAck) begin
                state_d = S_BLANK;
                cnt_d   = CW'(BLANK - 1);
            end
            S_BLANK: if (cnt_zero) begin
                state_d = S_DRIVE;
                cnt_d   = CW'(DWELL - 1);
            end else cnt_d = cnt_q - CW'(1);
            default: if (cnt_zero) begin
                // the pointer advances as the row ends, so IDLE keeps the resume point
                state_d = io_enable ? S_FETCH : S_IDLE;
                b_d     = last_b ? 4'd0 : b_q + 4'd1;
                r_d     = !last_b ? r_q : (last_r ? 6'd0 : r_q + 6'd1);
            end else cnt_d = cnt_q - CW'(1);
        endcase
    end

    assign drive_d      = state_d == S_DRIVE;
    assign latch_d      = drive_d && state_q != S_DRIVE;
    assign frame_done_d = drive_d && cnt_d == '0 && r_d == 6'(NUM_GROUPS - 1) && b_d == 4'(NUM_BLOCKS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            r_q          <= '0;
            b_q          <= '0;
            io_dataReq   <= 1'b0;
            io_nextRAddr <= '0;
            io_nextBAddr <= '0;
            io_rAddr     <= 6'h3F;
            io_bAddr     <= 4'hA;
            io_latch     <= 1'b0;
            io_frameDone <= 1'b0;
            io_busy      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            b_q          <= b_d;
            io_dataReq   <= state_d == S_FETCH;
            io_nextRAddr <= r_d;
            io_nextBAddr <= b_d;
            io_rAddr     <= drive_d ? r_d : 6'h3F;
            io_bAddr     <= drive_d ? b_d : 4'hA;
            io_latch     <= latch_d;
            io_frameDone <= frame_done_d;
            io_busy      <= state_d != S_IDLE;
        end
    end

`ifdef ROW_SCAN_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) io_frameCount <= '0;
        else if (io_frameCountClr) io_frameCount <= '0;
        else if (frame_done_d) io_frameCount <= io_frameCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_row_scan_sequencer.sv
// tb_row_scan_sequencer: constant vector table, directed corner sequences and random traffic against a row-schedule model.
module tb_row_scan_sequencer;
    localparam int NG = 19, NB = 9, DW = 4, BL = 1, NROWS = NG * NB;

    logic clk = 0, reset = 0, en = 0, ack = 0;
    logic       io_dataReq, io_latch, io_frameDone, io_busy;
    logic [5:0] io_nextRAddr, io_rAddr;
    logic [3:0] io_nextBAddr, io_bAddr;
`ifdef ROW_SCAN_FRAME_COUNT_EN
    logic        clr = 0;
    logic [15:0] fcount;
`endif

    always #5 clk = ~clk;

    row_scan_sequencer #(.NUM_GROUPS(NG), .NUM_BLOCKS(NB), .DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .reset(reset), .io_enable(en), .io_dataReq(io_dataReq), .io_dataAck(ack),
        .io_nextRAddr(io_nextRAddr), .io_nextBAddr(io_nextBAddr), .io_rAddr(io_rAddr), .io_bAddr(io_bAddr),
        .io_latch(io_latch), .io_frameDone(io_frameDone),
`ifdef ROW_SCAN_FRAME_COUNT_EN
        .io_frameCountClr(clr), .io_frameCount(fcount),
`endif
        .io_busy(io_busy)
    );

    typedef struct {
        bit          en;
        bit          ack;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl[17];

    int vectors = 0, miscompares = 0;
    // model: row index 0..NROWS-1 and position p in the row (0 fetch, 1..BL blank, BL+1..BL+DW drive)
    bit m_active;
    int m_p, m_idx, m_frames;

    function automatic logic [23:0] mk(bit busy, bit dreq, bit latch, bit fd, logic [5:0] r, logic [3:0] b,
                                       logic [5:0] nr, logic [3:0] nb);
        return {busy, dreq, latch, fd, r, b, nr, nb};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {io_busy, io_dataReq, io_latch, io_frameDone, io_rAddr, io_bAddr, io_nextRAddr, io_nextBAddr};
    endfunction

    function automatic logic [23:0] model_vec();
        bit drv = m_active && m_p >= 1 + BL;
        return mk(m_active, m_active && m_p == 0, drv && m_p == 1 + BL,
                  m_active && m_p == BL + DW && m_idx == NROWS - 1,
                  drv ? 6'(m_idx / NB) : 6'h3F, drv ? 4'(m_idx % NB) : 4'hA,
                  6'(m_idx / NB), 4'(m_idx % NB));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_p = 0; m_idx = 0; m_frames = 0;
    endtask

    task automatic model_step(input bit e, input bit a);
        if (!m_active) begin
            if (e) begin m_active = 1; m_p = 0; end
        end else if (m_p == 0) begin
            if (a) m_p = 1;
        end else if (m_p < BL + DW) m_p++;
        else begin
            m_idx = (m_idx + 1) % NROWS;
            if (e) m_p = 0; else m_active = 0;
        end
        if (m_active && m_p == BL + DW && m_idx == NROWS - 1) m_frames++;
    endtask

    task automatic step(input bit e, input bit a);
        en = e; ack = a;
        model_step(e, a);
        @(posedge clk);
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; en = 0; ack = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        int n, fds, len, prev;
        tbl[0]  = '{0, 1, mk(0, 0, 0, 0, 6'h3F, 4'hA, 0, 0)};
        tbl[1]  = '{1, 1, mk(1, 1, 0, 0, 6'h3F, 4'hA, 0, 0)};
        tbl[2]  = '{1, 1, mk(1, 0, 0, 0, 6'h3F, 4'hA, 0, 0)};
        tbl[3]  = '{1, 1, mk(1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1, 1, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1, 1, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1, 1, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1, 1, mk(1, 1, 0, 0, 6'h3F, 4'hA, 0, 1)};
        tbl[8]  = '{0, 1, mk(1, 0, 0, 0, 6'h3F, 4'hA, 0, 1)};
        tbl[9]  = '{0, 1, mk(1, 0, 1, 0, 0, 1, 0, 1)};
        tbl[10] = '{0, 1, mk(1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[11] = '{0, 1, mk(1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[12] = '{0, 1, mk(1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[13] = '{0, 1, mk(0, 0, 0, 0, 6'h3F, 4'hA, 0, 2)};
        tbl[14] = '{0, 1, mk(0, 0, 0, 0, 6'h3F, 4'hA, 0, 2)};
        tbl[15] = '{1, 0, mk(1, 1, 0, 0, 6'h3F, 4'hA, 0, 2)};
        tbl[16] = '{1, 0, mk(1, 1, 0, 0, 6'h3F, 4'hA, 0, 2)};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_out", dut_vec(), mk(0, 0, 0, 0, 6'h3F, 4'hA, 0, 0));
        reset = 1;
        for (int i = 0; i < 100; i++) step(0, i[0]);
        check("idle_hold", dut_vec(), mk(0, 0, 0, 0, 6'h3F, 4'hA, 0, 0));

        do_reset();
        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; ack = tbl[i].ack;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
        end

        do_reset();
        step(1, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0);
            check("stall", {io_dataReq, io_nextRAddr, io_nextBAddr, io_rAddr, io_bAddr},
                  {1'b1, 6'd0, 4'd0, 6'h3F, 4'hA});
        end
        n = 0;
        while (n < 10) begin
            step(1, 1);
            n++;
            if (io_rAddr != 6'h3F) break;
        end
        check("stall_to_drive", n, 1 + BL);

        do_reset();
        step(1, 1);
        fds = 0; len = -1; n = 1; prev = -1;
        for (int i = 0; i < 1100 && len < 0; i++) begin
            step(1, 1);
            n++;
            if (io_frameDone) fds++;
            if (io_dataReq && io_nextRAddr == 1 && io_nextBAddr == 0) check("wrap_0_8", prev, 8);
            if (io_dataReq) prev = io_nextRAddr * 16 + io_nextBAddr;
            if (io_dataReq && fds > 0 && io_nextRAddr == 0 && io_nextBAddr == 0) len = n - 1;
        end
        check("frame_len", len, NROWS * (1 + BL + DW));
        check("frame_done_cnt", fds, 1);

        do_reset();
        n = 0;
        while (!(io_rAddr == 2 && io_bAddr == 3) && n < 400) begin step(1, 1); n++; end
        check("reach_2_3", {io_rAddr, io_bAddr}, {6'd2, 4'd3});
        n = 0;
        while (io_busy && n < 20) begin step(0, 1); n++; end
        check("stop_idle", {io_busy, io_nextRAddr, io_nextBAddr}, {1'b0, 6'd2, 4'd4});
        repeat (5) step(0, 1);
        n = 0;
        while (!io_dataReq && n < 5) begin step(1, 1); n++; end
        check("resume_req", {io_dataReq, io_nextRAddr, io_nextBAddr}, {1'b1, 6'd2, 4'd4});

        do_reset();
        n = 0;
        while (!(io_rAddr == 5 && io_bAddr == 5) && n < 500) begin step(1, 1); n++; end
        check("reach_5_5", {io_rAddr, io_bAddr}, {6'd5, 4'd5});
        @(posedge clk);
        #2 reset = 0;
        #1 check("async_rst", {io_rAddr, io_bAddr, io_busy, io_latch}, {6'h3F, 4'hA, 1'b0, 1'b0});
        model_reset();
        @(negedge clk);
        reset = 1;
        step(1, 1);
        check("after_rst_req", {io_dataReq, io_nextRAddr, io_nextBAddr}, {1'b1, 6'd0, 4'd0});

        do_reset();
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)));

`ifdef ROW_SCAN_FRAME_COUNT_EN
        do_reset();
        check("fc_reset", fcount, 0);
        for (int i = 0; i < 3 * NROWS * (1 + BL + DW) + 20; i++) step(1, 1);
        check("fc_three", fcount, m_frames);
        check("fc_three_abs", fcount, 3);
        clr = 1;
        step(1, 1);
        clr = 0;
        check("fc_clr", fcount, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/row_scan_sequencer.md
Name: row_scan_sequencer

Overview:
- Address-side initiator that drives the grid row decoder.
- Walks every (group, block-row) pair of the 19x9 grid in order: requests column data for each row, blanks, then drives that row's address for a fixed dwell.
- Sits between the frame-buffer fetch logic and the row decoder.
- When not driving, outputs the all-off code: rAddr=6'h3F, bAddr=4'hA. No group matches this code, so every decoder output is 0.

Parameters:
NUM_GROUPS, 19, number of row groups (rAddr range 0..NUM_GROUPS-1)
NUM_BLOCKS, 9, block-rows per group (bAddr range 0..NUM_BLOCKS-1)
DWELL, 64, cycles each row is driven (>=1)
BLANK, 2, all-off cycles between data ack and drive (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
io_enable  input  1  level; 1 = scan frames continuously
io_dataReq  output  1  request column data for row (io_nextRAddr, io_nextBAddr)
io_dataAck  input  1  column data loaded; sampled only while io_dataReq=1
io_nextRAddr  output  6  group of the pending/current row
io_nextBAddr  output  4  block-row of the pending/current row
io_rAddr  output  6  to decoder; 6'h3F when not in DRIVE
io_bAddr  output  4  to decoder; 4'hA when not in DRIVE
io_latch  output  1  one-cycle pulse on first DRIVE cycle (column latch strobe)
io_frameDone  output  1  one-cycle pulse on last DRIVE cycle of row (NUM_GROUPS-1, NUM_BLOCKS-1)
io_busy  output  1  1 in any state except IDLE

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, row pointer=(0,0)
  - io_rAddr=6'h3F, io_bAddr=4'hA
  - all strobes 0, io_nextRAddr=0, io_nextBAddr=0
- All outputs are registered.
- States:
  - IDLE: outputs off. On io_enable=1 -> FETCH; pointer is (0,0).
  - FETCH: io_dataReq=1; next* hold the pointer stable. On io_dataAck=1 in the same cycle -> BLANK with counter=BLANK-1. Waits indefinitely; outputs stay off.
  - BLANK: outputs off; counter decrements; at 0 -> DRIVE with counter=DWELL-1.
  - DRIVE: io_rAddr/io_bAddr = pointer; io_latch=1 on entry cycle only; counter decrements; at 0 -> advance.
- Advance order: bAddr increments 0..NUM_BLOCKS-1; on wrap, bAddr->0 and rAddr increments; after (NUM_GROUPS-1, NUM_BLOCKS-1), pointer wraps to (0,0).
- On the cycle DRIVE ends:
  - if the row just driven was the last row, io_frameDone=1 that cycle.
  - next state = FETCH if io_enable=1, else IDLE.
  - the pointer is already advanced when entering FETCH or IDLE.
- io_enable deassert mid-row: the current phase (FETCH, BLANK or DRIVE) completes; the block then stops at the row boundary in IDLE with the pointer saved. Re-enable resumes at the saved pointer, not (0,0). If io_enable drops during FETCH, the FETCH still completes on ack.
- Row period with ack in the first FETCH cycle: 1 + BLANK + DWELL cycles (67 default). Frame = 171 rows x 67 = 11457 cycles.
- No two rows are ever driven back to back: at least BLANK off cycles separate DRIVE phases.
- io_dataAck while io_dataReq=0 is ignored.
- Reset asserted mid-DRIVE forces outputs off immediately (async).
- Width rules:
  - counters are sized clog2(max(DWELL,BLANK)+1).
  - the pointer compares against NUM_*-1 exactly; it never reaches 6'h3F or 4'hA.

Optional Feature:
- Macro ROW_SCAN_FRAME_COUNT_EN.
- Defined:
  - adds output io_frameCount [15:0], reset 0.
  - increments on every io_frameDone pulse and wraps 16'hFFFF->0.
  - also adds input io_frameCountClr; a sync clear that wins over a simultaneous increment.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset values: hold reset=0 -> io_rAddr=6'h3F, io_bAddr=4'hA, io_busy=0, io_dataReq=0. Release with io_enable=0 -> unchanged for 100 cycles.
- Single row (DWELL=4, BLANK=1), io_enable=1, io_dataAck tied 1:
  - cycle 1: io_dataReq=1 with next=(0,0).
  - cycle 2: off.
  - cycles 3-6: io_rAddr=0, io_bAddr=0, io_latch=1 on cycle 3 only.
  - cycle 7: io_dataReq=1 with next=(0,1).
- Ack stall: hold io_dataAck=0 for 20 cycles -> io_dataReq stays 1, next* stable, decoder address stays 3F/A. Ack on cycle 21 -> DRIVE begins 1+BLANK cycles later.
- Wrap and frame (DWELL=4, BLANK=1, ack=1):
  - row (0,8) is followed by (1,0).
  - io_frameDone pulses exactly once on the last cycle of row (18,8).
  - the next request is (0,0).
  - frame length = 171*6 = 1026 cycles.
- Stop/resume: drop io_enable during DRIVE of (2,3) -> the row finishes, state goes to IDLE, io_busy=0. Re-enable -> first io_dataReq is for (2,4).
- Async reset during DRIVE of (5,5) -> outputs go to 3F/A within the same cycle. After release with enable=1, the first request is (0,0). With ROW_SCAN_FRAME_COUNT_EN: the count is 0 after reset and reads 3 after three full frames.
